win_line_feed: RTL and testbench

WIN_LINE_FEED -- requirements
Module: win_line_feed

---
 rtl/win_line_feed.sv | 149 ++++++++++++++
 tb/tb_win_line_feed.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/win_line_feed.sv
// rtl/win_line_feed.sv - raster-to-column feeder for a vertical sliding window
// Keeps WIN_SIZE-1 previous lines and emits one zero-padded vertical column per pixel position.
module win_line_feed #(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DIN_WIDTH   = 8,
  parameter int WIN_SIZE    = 3,
  parameter int CH_NUM      = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [$clog2(FRAME_H_MAX-1):0]         frame_h,
  input  logic [$clog2(FRAME_W_MAX-1):0]         frame_w,
  input  logic                                   frame_start,
  input  logic                                   pix_vld,
  input  logic [CH_NUM*DIN_WIDTH-1:0]            pix,
  output logic                                   pix_rdy,
  output logic                                   col_frame_start,
  output logic                                   col_vld,
  output logic [WIN_SIZE*CH_NUM*DIN_WIDTH-1:0]   col
);

  localparam int HW    = $clog2(FRAME_H_MAX-1) + 1;
  localparam int WW    = $clog2(FRAME_W_MAX-1) + 1;
  localparam int AW    = (FRAME_W_MAX > 1) ? $clog2(FRAME_W_MAX) : 1;
  localparam int RW    = HW + 1;
  localparam int PW    = CH_NUM * DIN_WIDTH;
  localparam int WIN_R = WIN_SIZE / 2;
  localparam int NL    = WIN_SIZE - 1;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_FLUSH} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [HW-1:0]         r_frame_h;
  logic [WW-1:0]         r_frame_w;
  logic [HW-1:0]         r_row;
  logic [WW-1:0]         r_col_idx;
  logic [PW-1:0]         r_line [NL][FRAME_W_MAX];

  logic                  w_xfer;
  logic                  w_flush_step;
  logic                  w_adv;
  logic                  w_emit;
  logic                  w_col_last;
  logic [AW-1:0]         w_addr;
  logic [RW-1:0]         w_row_ext;
  logic [RW-1:0]         w_h_ext;
  logic [PW-1:0]         w_tap [WIN_SIZE];
  logic [WIN_SIZE*PW-1:0] w_col_nxt;

  assign pix_rdy      = ((r_state == S_PRIME) || (r_state == S_STREAM)) && !frame_start;
  assign w_xfer       = pix_vld && pix_rdy;
  assign w_flush_step = (r_state == S_FLUSH) && !frame_start;
  assign w_adv        = w_xfer || w_flush_step;
  assign w_emit       = (w_xfer && (r_state == S_STREAM)) || w_flush_step;
  assign w_col_last   = (r_col_idx == r_frame_w - 1'b1);
  assign w_addr       = r_col_idx[AW-1:0];
  assign w_row_ext    = {1'b0, r_row};
  assign w_h_ext      = {1'b0, r_frame_h};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      w_state_nxt = S_PRIME;
    end else begin
      case (r_state)
        S_PRIME:  if (w_xfer && w_col_last && (r_row == HW'(WIN_R - 1)))
                    w_state_nxt = S_STREAM;
        S_STREAM: if (w_xfer && w_col_last && (r_row == r_frame_h - 1'b1))
                    w_state_nxt = S_FLUSH;
        S_FLUSH:  if (w_col_last && (r_row == r_frame_h + HW'(WIN_R - 1)))
                    w_state_nxt = S_IDLE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row     <= '0;
      r_col_idx <= '0;
      r_frame_h <= '0;
      r_frame_w <= '0;
    end else if (frame_start) begin
      r_row     <= '0;
      r_col_idx <= '0;
      r_frame_h <= frame_h;
      r_frame_w <= frame_w;
    end else if (w_adv) begin
      if (w_col_last) begin
        r_col_idx <= '0;
        r_row     <= r_row + 1'b1;
      end else begin
        r_col_idx <= r_col_idx + 1'b1;
      end
    end
  end

  // Line k at address c holds row r-1-k; shifting on every advance keeps that true through flush.
  always_ff @(posedge clk) begin
    if (!reset && w_adv) begin
      r_line[0][w_addr] <= (r_state == S_FLUSH) ? '0 : pix;
      for (int k = 1; k < NL; k++) begin
        r_line[k][w_addr] <= r_line[k-1][w_addr];
      end
    end
  end

  always_comb begin
    w_tap[0] = pix;
    for (int k = 1; k < WIN_SIZE; k++) begin
      w_tap[k] = r_line[k-1][w_addr];
    end
  end

  // Tap k carries row r-k; zero it above the frame top or below the frame bottom.
  always_comb begin
    w_col_nxt = '0;
    for (int k = 0; k < WIN_SIZE; k++) begin
      if ((w_row_ext >= RW'(k)) && (w_row_ext < w_h_ext + RW'(k))) begin
        w_col_nxt[k*PW +: PW] = w_tap[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_vld         <= 1'b0;
      col_frame_start <= 1'b0;
      col             <= '0;
    end else begin
      col_vld         <= w_emit;
      col_frame_start <= frame_start;
      if (w_emit) begin
        col <= w_col_nxt;
      end
    end
  end

endmodule

// File: tb/tb_win_line_feed.sv
// tb/tb_win_line_feed.sv - directed self-checking bench for win_line_feed
// WIN_SIZE=3, CH_NUM=1, pixel value 16*row+col+1 (+offset for a second frame).
module tb_win_line_feed;
  localparam int FH = 224;
  localparam int FW = 224;
  localparam int DW = 8;
  localparam int WS = 3;
  localparam int CH = 1;
  localparam int HW = $clog2(FH-1) + 1;
  localparam int WWD = $clog2(FW-1) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [HW-1:0]     frame_h;
  logic [WWD-1:0]    frame_w;
  logic              frame_start;
  logic              pix_vld;
  logic [CH*DW-1:0]  pix;
  logic              pix_rdy;
  logic              col_frame_start;
  logic              col_vld;
  logic [WS*CH*DW-1:0] col;

  int checks = 0;
  int errors = 0;
  logic [23:0] got[$];

  always #5 clk = ~clk;

  win_line_feed #(
    .FRAME_H_MAX(FH), .FRAME_W_MAX(FW), .DIN_WIDTH(DW), .WIN_SIZE(WS), .CH_NUM(CH)
  ) dut (
    .clk(clk), .reset(reset), .frame_h(frame_h), .frame_w(frame_w),
    .frame_start(frame_start), .pix_vld(pix_vld), .pix(pix), .pix_rdy(pix_rdy),
    .col_frame_start(col_frame_start), .col_vld(col_vld), .col(col)
  );

  always @(negedge clk) begin
    if (col_vld) got.push_back(col);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Column centred on raster index n: col[k] is row (centre+1-k), zero outside the frame.
  function automatic logic [23:0] exp_col(input int h, input int w, input int off, input int n);
    int rc;
    int c;
    int row;
    logic [23:0] v;
    rc = n / w;
    c  = n % w;
    v  = '0;
    for (int k = 0; k < 3; k++) begin
      row = rc + 1 - k;
      if (row >= 0 && row < h) v[k*8 +: 8] = 8'(16*row + c + 1 + off);
    end
    return v;
  endfunction

  task automatic start_frame(input int h, input int w, input logic vld, input logic [7:0] p);
    @(negedge clk);
    frame_h = HW'(h);
    frame_w = WWD'(w);
    frame_start = 1'b1;
    pix_vld = vld;
    pix = p;
    #1;
    check("fs_rdy", pix_rdy, 0);
    @(negedge clk);
    frame_start = 1'b0;
    pix_vld = 1'b0;
    #1;
    check("col_fs_pulse", col_frame_start, 1);
    check("col_fs_no_vld", col_vld, 0);
  endtask

  task automatic send_pixels(input int w, input int off, input int n, input bit gaps);
    int idx = 0;
    int guard = 0;
    int bad_vld = 0;
    bit prev_emit = 0;
    while (idx < n && guard < 2000) begin
      @(negedge clk);
      if (col_vld !== prev_emit) bad_vld++;
      pix_vld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix = 8'(16*(idx/w) + idx%w + 1 + off);
      #1;
      prev_emit = 0;
      if (pix_vld && pix_rdy) begin
        prev_emit = ((idx / w) >= 1);
        idx++;
      end
      guard++;
    end
    check("send_count", idx, n);
    check("vld_timing", bad_vld, 0);
    @(negedge clk);
    pix_vld = 1'b0;
    #1;
  endtask

  task automatic check_flush(input int n);
    int good = 0;
    for (int i = 0; i < n; i++) begin
      if (!pix_rdy && col_vld) good++;
      @(negedge clk);
      #1;
    end
    check("flush_run", good, n);
    check("last_col_vld", col_vld, 1);
    check("idle_rdy", pix_rdy, 0);
    @(negedge clk);
    #1;
    check("idle_vld", col_vld, 0);
  endtask

  task automatic check_seq(input string tag, input int base, input int h, input int w, input int off);
    int bad = 0;
    for (int i = 0; i < h*w; i++) begin
      if (base + i >= got.size()) bad++;
      else if (got[base+i] !== exp_col(h, w, off, i)) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int bad;
    reset = 1'b1; frame_start = 1'b0; pix_vld = 1'b0; pix = '0; frame_h = '0; frame_w = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pix_rdy", pix_rdy, 0);
    check("rst_col_vld", col_vld, 0);
    check("rst_col_fs", col_frame_start, 0);
    check("rst_col", col, 0);
    @(negedge clk);
    reset = 1'b0;

    // back-to-back 4x4 frame
    start_frame(4, 4, 1'b0, 8'h00);
    send_pixels(4, 0, 16, 0);
    check_flush(4);
    check("b2b_count", got.size(), 16);
    check("b2b_first", got[0], 24'h000111);
    check("b2b_last", got[15], 24'h243400);
    check_seq("b2b_seq", 0, 4, 4, 0);
    got.delete();

    // same frame with random valid gaps
    start_frame(4, 4, 1'b0, 8'h00);
    send_pixels(4, 0, 16, 1);
    check_flush(4);
    check("gap_count", got.size(), 16);
    check_seq("gap_seq", 0, 4, 4, 0);
    got.delete();

    // abort at (2,1) and restart with a distinct pixel set
    start_frame(4, 4, 1'b0, 8'h00);
    send_pixels(4, 0, 9, 0);
    start_frame(4, 4, 1'b1, 8'd34);
    check("abort_old_count", got.size(), 5);
    send_pixels(4, 128, 16, 0);
    check_flush(4);
    check("abort_total", got.size(), 21);
    check("abort_first_new", got[5], 24'h008191);
    check_seq("abort_seq", 5, 4, 4, 128);
    got.delete();

    // reset mid-stream with a pixel offered
    start_frame(4, 4, 1'b0, 8'h00);
    send_pixels(4, 0, 6, 0);
    pix_vld = 1'b1;
    pix = 8'd19;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_vld", col_vld, 0);
    check("rst_mid_col", col, 0);
    check("rst_mid_fs", col_frame_start, 0);
    check("rst_mid_rdy", pix_rdy, 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (pix_rdy || col_vld) bad++;
    end
    check("rst_mid_idle", bad, 0);
    pix_vld = 1'b0;
    check("rst_mid_count", got.size(), 2);
    got.delete();

    // minimum-height 2x3 frame
    start_frame(2, 3, 1'b0, 8'h00);
    send_pixels(3, 0, 6, 0);
    check_flush(3);
    check("small_count", got.size(), 6);
    check("small_last", got[5], 24'h031300);
    check_seq("small_seq", 0, 2, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
